// File: rtl/seg7_capture.sv
// seg7_capture: watches active-low seven-segment buses, waits for the whole
// display to hold steady, then decodes every digit to a hex nibble with
// blank / error flags and a one-cycle valid pulse.
// Optional feature macro: SEG7_CAPTURE_DP_EN (decimal points captured and
// included in stability checks). Without it dp is 0 and DP bits are ignored.
//
// state    | meaning
// ST_IDLE  | capture disabled, counter cleared
// ST_WAIT  | counting consecutive unchanged cycles
// ST_LOCKED| outputs captured, watching for a change from the locked pattern
module seg7_capture #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] segs_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    valid,
  output logic                    busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
`ifdef SEG7_CAPTURE_DP_EN
  localparam logic [8*NUM_DIGITS-1:0] CMP_MASK = {NUM_DIGITS{8'hFF}};
`else
  localparam logic [8*NUM_DIGITS-1:0] CMP_MASK = {NUM_DIGITS{8'h7F}};
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*NUM_DIGITS-1:0] segs_q, segs_d;
  logic [8*NUM_DIGITS-1:0] segs_p_q, segs_p_d;
  logic [8*NUM_DIGITS-1:0] segs_lock_q, segs_lock_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic [4*NUM_DIGITS-1:0] dec_value;
  logic [NUM_DIGITS-1:0]   dec_blank;
  logic [NUM_DIGITS-1:0]   dec_err;
  logic [NUM_DIGITS-1:0]   dec_dp;
  logic                    same_prev;
  logic                    same_lock;

  // Inverse of the team encoder; returns {err, blank, nibble}.
  function automatic logic [5:0] decode_glyph(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h40:   r = 6'h00;
      7'h79:   r = 6'h01;
      7'h24:   r = 6'h02;
      7'h30:   r = 6'h03;
      7'h19:   r = 6'h04;
      7'h12:   r = 6'h05;
      7'h02:   r = 6'h06;
      7'h78:   r = 6'h07;
      7'h00:   r = 6'h08;
      7'h10:   r = 6'h09;
      7'h08:   r = 6'h0A;
      7'h03:   r = 6'h0B;
      7'h46:   r = 6'h0C;
      7'h21:   r = 6'h0D;
      7'h06:   r = 6'h0E;
      7'h0E:   r = 6'h0F;
      7'h7F:   r = 6'b01_0000;
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // Per-digit decode of the registered input copy.
  always_comb begin
    logic [5:0] d;
    dec_value = '0;
    dec_blank = '0;
    dec_err   = '0;
    dec_dp    = '0;
    d         = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d                  = decode_glyph(segs_q[8*i +: 7]);
      dec_value[4*i +: 4] = d[3:0];
      dec_blank[i]       = d[4];
      dec_err[i]         = d[5];
`ifdef SEG7_CAPTURE_DP_EN
      dec_dp[i]          = ~segs_q[8*i + 7];
`endif
    end
  end

  // Next-state logic: stability counter, capture and lock tracking.
  always_comb begin
    same_prev   = ((segs_q ^ segs_p_q) & CMP_MASK) == '0;
    same_lock   = ((segs_q ^ segs_lock_q) & CMP_MASK) == '0;
    segs_d      = segs_in;
    segs_p_d    = segs_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    segs_lock_d = segs_lock_q;
    value_d     = value_q;
    blank_d     = blank_q;
    err_d       = err_q;
    dp_d        = dp_q;
    valid_d     = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
        ST_WAIT: begin
          // a change on the terminal-count cycle wins over the capture
          if (!same_prev) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_TERM) begin
            value_d     = dec_value;
            blank_d     = dec_blank;
            err_d       = dec_err;
            dp_d        = dec_dp;
            segs_lock_d = segs_q;
            valid_d     = 1'b1;
            cnt_d       = '0;
            state_d     = ST_LOCKED;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!same_lock) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_WAIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      segs_q      <= '1;
      segs_p_q    <= '1;
      segs_lock_q <= '1;
      value_q     <= '0;
      blank_q     <= '0;
      err_q       <= '0;
      dp_q        <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      segs_q      <= segs_d;
      segs_p_q    <= segs_p_d;
      segs_lock_q <= segs_lock_d;
      value_q     <= value_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign value = value_q;
  assign blank = blank_q;
  assign err   = err_q;
  assign dp    = dp_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_seg7_capture;
  localparam int N = 6;
  localparam int S = 16;
  localparam logic [47:0] BASE = 48'hC0F9A4B09992;
`ifdef SEG7_CAPTURE_DP_EN
  localparam logic [8*N-1:0] MASK = {N{8'hFF}};
  localparam bit DP_ON = 1'b1;
`else
  localparam logic [8*N-1:0] MASK = {N{8'h7F}};
  localparam bit DP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic [8*N-1:0] segs_in;
  logic [4*N-1:0] value;
  logic [N-1:0]   blank, err, dp;
  logic           valid, busy;

  int checks = 0;
  int errors = 0;

  seg7_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .segs_in(segs_in),
    .value(value), .blank(blank), .err(err), .dp(dp),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // glyph table: index = hex digit, entry = active-low pattern on bits 6..0
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- behavioural model ----------------
  // mq/mp: the two most recent input samples; mlock: pattern of last capture.
  // A capture happens S edges after the current run of unchanged display began.
  logic [8*N-1:0] mq, mp, mlock;
  int             mmode;      // 0 disabled, 1 waiting, 2 locked
  int             edge_n, run_start;
  logic [4*N-1:0] m_value;
  logic [N-1:0]   m_blank, m_err, m_dp;
  logic           m_valid, m_busy;

  task automatic model_capture();
    logic [7:0] b;
    bit found;
    for (int i = 0; i < N; i++) begin
      b = mq[8*i +: 8];
      found = 1'b0;
      m_value[4*i +: 4] = 4'h0;
      m_blank[i] = 1'b0;
      m_err[i] = 1'b0;
      for (int g = 0; g < 16; g++)
        if (glyph[g] == b[6:0]) begin
          m_value[4*i +: 4] = 4'(g);
          found = 1'b1;
        end
      if (!found) begin
        if (b[6:0] == 7'h7F) m_blank[i] = 1'b1;
        else m_err[i] = 1'b1;
      end
      m_dp[i] = DP_ON ? ~b[7] : 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq = '1; mp = '1; mlock = '1;
      mmode = 0; edge_n = 0; run_start = 0;
      m_value = '0; m_blank = '0; m_err = '0; m_dp = '0;
      m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      bit eq, leq;
      edge_n++;
      eq  = ((mq ^ mp) & MASK) == '0;
      leq = ((mq ^ mlock) & MASK) == '0;
      m_valid = 1'b0;
      if (!en) mmode = 0;
      else if (mmode == 0) begin
        mmode = 1; run_start = edge_n;
      end else if (mmode == 1) begin
        if (!eq) run_start = edge_n;
        else if (edge_n - run_start == S) begin
          model_capture();
          mlock = mq; m_valid = 1'b1; mmode = 2;
        end
      end else if (!leq) begin
        mmode = 1; run_start = edge_n;
      end
      m_busy = (mmode == 1);
      mp = mq;
      mq = segs_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (value !== m_value || blank !== m_blank || err !== m_err || dp !== m_dp ||
        valid !== m_valid || busy !== m_busy || (valid && prev_valid)) begin
      errors++;
      if (errors < 30)
        $display("FAIL model_cmp t=%0t got v=%h b=%b e=%b dp=%b val=%b busy=%b required v=%h b=%b e=%b dp=%b val=%b busy=%b",
                 $time, value, blank, err, dp, valid, busy,
                 m_value, m_blank, m_err, m_dp, m_valid, m_busy);
    end
    prev_valid = valid;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  // posedges until valid is seen; -1 on timeout
  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if (valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_cycles(input int n, output int nvalid, output int nbusy);
    nvalid = 0; nbusy = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (busy) nbusy++;
    end
  endtask

  function automatic logic [7:0] rand_digit();
    int r;
    logic [6:0] s;
    r = $urandom_range(0, 9);
    if (r < 6) s = glyph[$urandom_range(0, 15)];
    else if (r < 8) s = 7'h7F;
    else s = 7'($urandom);
    return {1'($urandom), s};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat, nv, nb;
    reset_n = 1'b0; en = 1'b0; segs_in = '1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({value, blank, err, dp, valid, busy}), 64'h0);

    // basic capture
    segs_in = BASE; en = 1'b1; reset_n = 1'b1;
    wait_valid(60, lat);
    chk("basic_latency", 64'(lat), 64'd18);
    chk("basic_value", 64'(value), 64'h012345);
    chk("basic_blank_err", 64'({blank, err}), 64'h0);
    count_cycles(40, nv, nb);
    chk("basic_no_revalid", 64'(nv), 64'd0);

    // glitch restart
    segs_in = {N{8'hC0}};
    count_cycles(10, nv, nb);
    chk("glitch_no_early_valid", 64'(nv), 64'd0);
    segs_in = 48'hC0F9A4B09982;
    wait_valid(60, lat);
    chk("glitch_latency", 64'(lat), 64'd18);
    chk("glitch_value", 64'(value), 64'h012346);

    // blank and error
    segs_in = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hAA, 8'hFF};
    wait_valid(60, lat);
    chk("blank_flags", 64'(blank), 64'h01);
    chk("err_flags", 64'(err), 64'h02);
    chk("blank_err_value", 64'(value), 64'h0);

    // decimal point
    segs_in = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40};
    wait_valid(60, lat);
    chk("dp_bit", 64'(dp), DP_ON ? 64'h01 : 64'h00);
    chk("dp_value0", 64'(value[3:0]), 64'h0);
    segs_in = {N{8'hC0}};
`ifdef SEG7_CAPTURE_DP_EN
    wait_valid(60, lat);
    chk("dp_cleared", 64'(dp), 64'h0);
`else
    count_cycles(25, nv, nb);
    chk("dp_toggle_no_valid", 64'(nv), 64'd0);
    chk("dp_toggle_no_busy", 64'(nb), 64'd0);
`endif

    // enable drop during wait
    segs_in = BASE;
    repeat (5) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    en = 1'b0;
    count_cycles(30, nv, nb);
    chk("endrop_no_valid", 64'(nv), 64'd0);
    chk("endrop_no_busy", 64'(nb), 64'd0);
    segs_in = 48'hC0F9A4B09982; en = 1'b1;
    wait_valid(60, lat);
    chk("reenable_latency", 64'(lat), 64'd18);
    chk("reenable_value", 64'(value), 64'h012346);

    // reset mid-wait
    segs_in = BASE;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midreset_outputs", 64'({value, blank, err, dp, valid, busy}), 64'h0);
    count_cycles(3, nv, nb);
    chk("midreset_no_valid", 64'(nv), 64'd0);
    reset_n = 1'b1;
    wait_valid(60, lat);
    chk("postreset_latency", 64'(lat), 64'd18);

    // randomized phase
    for (int it = 0; it < 300; it++) begin
      int r, d;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        en = 1'b1;
      end else if (r == 1) begin
        d = $urandom_range(0, N - 1);
        segs_in[8*d + 7] = ~segs_in[8*d + 7];
      end else if (r < 4) begin
        d = $urandom_range(0, N - 1);
        segs_in[8*d +: 8] = rand_digit();
      end else begin
        for (int i = 0; i < N; i++) segs_in[8*i +: 8] = rand_digit();
      end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Monitor/decoder for the active-low 8-bit seven-segment display buses driven by the digit encoders on the De10Lite top level. It samples `NUM_DIGITS` segment buses, waits until the whole display has been stable for a programmable number of cycles, and decodes each pattern back to a hex nibble, with blank and error flags. It closes the display path for self-test: firmware or a bench checks that what reaches the displays matches what the CPU wrote.

## Interface
- `NUM_DIGITS`, 6: number of display digits monitored; minimum 1.
- `STABLE_CYCLES`, 16: consecutive unchanged cycles required before capture; minimum 1.
- `clk`  in  1: single clock; all state on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: capture enable.
- `segs_in`  in  8*NUM_DIGITS: digit i on bits [8i+7:8i]. Bit 7 is DP; bits 6..0 are segments g..a. All are active-low (0 = lit).
- `value`  out  4*NUM_DIGITS: decoded nibble for digit i on [4i+3:4i].
- `blank`  out  NUM_DIGITS: digit i has all segments a..g off.
- `err`  out  NUM_DIGITS: digit i pattern is neither a valid hex glyph nor blank.
- `dp`  out  NUM_DIGITS: digit i decimal point lit (see Configuration).
- `valid`  out  1: one-cycle pulse when `value`/`blank`/`err`/`dp` update.
- `busy`  out  1: high while waiting for stability.

## Operation
- Input stage: `segs_in` is registered into `segs_q` every cycle. The previous copy is held in `segs_p`.
- The decode table, on bits 6..0, is the exact inverse of the team encoder:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10
  - A:08, b:03, C:46, d:21, E:06, F:0E
- 7F decodes as blank: value 0, blank 1, err 0.
- Any other code decodes as an error: value 0, err 1, blank 0.
- DP never affects value, blank or err.
- States:
  - IDLE: counter 0, busy 0. Moves to WAIT when `en`=1.
  - WAIT: busy 1.
    - If `segs_q`≠`segs_p`, the counter clears.
    - Otherwise the counter increments.
    - When the counter reaches STABLE_CYCLES-1 and `segs_q`==`segs_p`: register decoded outputs, latch `segs_q` as `segs_lock`, pulse `valid`, go to LOCKED.
  - LOCKED: busy 0, outputs held. If `segs_q`≠`segs_lock`: counter 0, go to WAIT.
    - Returning to the same locked pattern after a change still re-captures and pulses `valid`.
- `en`=0 in any state: next state IDLE, counter 0, outputs hold their last captured values, no `valid`.
- Counter width is $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state IDLE, counter 0.
  - `segs_q`, `segs_p`, `segs_lock` all ones.
  - `value`, `blank`, `err`, `dp`, `valid`, `busy` all 0.
- Reset asserted mid-WAIT or mid-LOCKED aborts immediately. No `valid` is emitted from partial state.
- Capture latency: with `en`=1 and `segs_in` changed just before edge k and held, `valid` is high in the cycle after edge k+STABLE_CYCLES+1. This is 1 input register + STABLE_CYCLES compares + 1 output register. Outputs change on the same edge that raises `valid`.
- `valid` is high for exactly one cycle per capture. It is never high two consecutive cycles.
- A change in the same cycle as the terminal count takes priority: no capture, counter clears.
- `busy` is registered and rises one cycle after the IDLE→WAIT or LOCKED→WAIT transition condition.

## Configuration
- `SEG7_CAPTURE_DP_EN`, defined: `dp[i]` = ~`segs_q[8i+7]`, captured with the other outputs. DP changes count as changes for stability.
- Undefined: `dp` is tied to 0. Bit 7 of each digit is masked out of every stability comparison, so DP toggling never restarts the counter or leaves LOCKED.

## Test plan
- **Basic capture.** STABLE_CYCLES=16. Release reset, set `en`=1, hold `segs_in` = 48'hC0F9A4B09992 (digits 5..0 = 0,1,2,3,4,5).
  - Required: `valid` exactly 18 cycles later; `value`=24'h012345, `blank`=0, `err`=0; then no further `valid` while input is held.
- **Glitch restart.** Apply the above, then at cycle 10 change digit0 to 0x82 and hold.
  - Required: single `valid` 18 cycles after the change, `value`=24'h012346.
- **Blank and error.** digit0=0xFF, digit1=0xAA, others 0xC0.
  - Required: `blank`=6'b000001, `err`=6'b000010, `value`=24'h000000.
- **DP.** digit0=0x40. With macro: `dp[0]`=1, `value[3:0]`=0. Without macro: `dp`=0, `value[3:0]`=0.
  - Additionally, without the macro, toggling bit 7 while LOCKED produces no `valid` and `busy` stays 0.
- **Reset and enable.** Drop `reset_n` at WAIT count 8: all outputs 0 within the same cycle, no `valid`. Drop `en` in WAIT: return to IDLE, no `valid`.
  - Then re-enable: full 18-cycle capture latency.
